stack_ctrl_fsm: RTL
===================

# stack_ctrl_fsm

Multicycle control FSM for the 8-bit stack processor. It sequences fetch, decode, stack pop/push, data-memory access and branches, driving the datapath's ALU (`alu_op` 00 = ADD, 01 = SUB, 10 = NOT, 11 = AND), stack, PC/IR and memory enables. It sits beside the datapath and consumes the instruction opcode, the ALU `zero` flag and the stack status. It also traps on stack underflow and overflow.

## Interface
- Parameters: none.
- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: leave IDLE and begin fetching; sampled only in IDLE.
- `opcode` input 3: IR[7:5]. 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ.
- `zero` input 1: ALU zero flag, combinational from the datapath.
- `stack_empty` input 1: stack holds no entries.
- `stack_full` input 1: stack at capacity.
- `busy` output 1: state is neither IDLE nor TRAP.
- `trap` output 1: stack error; sticky.
- `instr_done` output 1: one-cycle pulse in the final state of each instruction.
- `pc_write` output 1: load PC.
- `pc_src` output 1: 0 = PC+1, 1 = IR[4:0] address.
- `iord` output 1: memory address mux. 0 = PC, 1 = IR[4:0].
- `mem_read`, `mem_write`, `ir_write`, `mdr_load` outputs 1 each: memory and register enables.
- `push`, `pop` outputs 1 each: stack operations.
- `push_src` output 1: 0 = ALU result, 1 = MDR.
- `a_load`, `b_load` outputs 1 each: latch stack-top data into the A or B register.
- `alu_op` output 2: ALU operation select.
- `alu_srcb` output 1: 0 = B register, 1 = constant 8'h00.

## Operation
- Unlisted outputs are 0 in every state. All outputs are a decode of state only (Moore), except `pc_write` in JZ_EVAL.
- IDLE: if `start` → FETCH.
- FETCH:
  - Asserts `mem_read`, `ir_write`, `pc_write` with `pc_src`=0 and `iord`=0.
  - → DECODE.
- DECODE, branching on `opcode`:
  - ADD/SUB/AND/NOT/POP/JZ: if `stack_empty` → TRAP.
  - ADD/SUB/AND/NOT → POP_A.
  - POP → POP_RD.
  - JZ → JZ_TOS.
  - PUSH: if `stack_full` → TRAP, else → PUSH_RD.
  - JMP → JMP.
- POP_A:
  - Asserts `pop` and `a_load`.
  - NOT → ALU_WB.
  - Otherwise, if `stack_empty` (sampled this cycle, i.e. after this pop) → TRAP, else → POP_B.
- POP_B: asserts `pop` and `b_load`. → ALU_WB.
- ALU_WB:
  - Asserts `push` with `push_src`=0 and `instr_done`.
  - `alu_op`: ADD 00, SUB 01, NOT 10, AND 11. SUB computes A − B = (old top) − (next).
  - → FETCH.
- PUSH_RD: asserts `mem_read`, `iord`=1, `mdr_load`. → PUSH_WB.
- PUSH_WB: asserts `push`, `push_src`=1, `instr_done`. → FETCH.
- POP_RD: asserts `pop` and `a_load`. → POP_WR.
- POP_WR: asserts `mem_write`, `iord`=1 (stores A), `instr_done`. → FETCH.
- JMP: asserts `pc_write`, `pc_src`=1, `instr_done`. → FETCH.
- JZ_TOS: asserts `a_load` without popping. → JZ_EVAL.
- JZ_EVAL:
  - Drives `alu_op`=00 and `alu_srcb`=1.
  - Asserts `pc_write` = `zero` with `pc_src`=1, and `instr_done`.
  - → FETCH.
- TRAP: `trap`=1, all enables 0. Leaves only via reset.

## Timing
- Reset: asynchronous; state → IDLE. Every output is 0 while `rst_n`=0 and in IDLE.
- Reset mid-instruction:
  - The FSM is in IDLE immediately after `rst_n` falls.
  - No push, pop, memory write or PC write occurs after reset assertion.
- Start latency: `start` high at edge N → FETCH during cycle N+1. `start` is ignored outside IDLE.
- Cycles from FETCH through the final state, inclusive:
  - ADD/SUB/AND: 5.
  - NOT, PUSH, POP, JZ: 4.
  - JMP: 3.
- The next FETCH follows on the very next cycle; there are no idle cycles between instructions.
- `instr_done` is high exactly one cycle per retired instruction and never in TRAP.
- Datapath registers load on the same rising edge that ends the state asserting their enable.

## Test plan
- Reset then `start` with ADD, stack not empty → states FETCH, DECODE, POP_A, POP_B, ALU_WB. `alu_op`=00 and `push`=1 in cycle 5; `instr_done` high in cycle 5 only.
- SUB with operands A=8'h05, B=8'h07 from a stack model → pushed value 8'hFE. NOT on 8'h0F → 8'hF0. AND 8'h3C, 8'h0F → 8'h0C.
- JZ with top = 8'h00 → `pc_write`=1 and `pc_src`=1 in JZ_EVAL. With top = 8'h01 → `pc_write`=0, and the next FETCH uses PC+1.
- PUSH with `stack_full`=1 → TRAP after DECODE: `trap`=1, `busy`=0, no `push`. Likewise ADD with exactly one stack entry → TRAP after POP_A.
- `rst_n` pulsed low during PUSH_RD → outputs all 0 immediately; IDLE held until `start`; no `push` observed.
- Back-to-back JMP, POP, NOT → 3 + 4 + 4 = 11 cycles with three `instr_done` pulses; `mem_write` with `iord`=1 only in POP_WR.

Source files
------------

// File: rtl/stack_ctrl_fsm_if.sv
// Control/status bundle between the stack-processor control FSM and its datapath.
interface stack_ctrl_fsm_if;
   logic       start;
   logic [2:0] opcode;
   logic       zero;
   logic       stack_empty;
   logic       stack_full;

   logic       busy;
   logic       trap;
   logic       instr_done;
   logic       pc_write;
   logic       pc_src;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mdr_load;
   logic       push;
   logic       pop;
   logic       push_src;
   logic       a_load;
   logic       b_load;
   logic [1:0] alu_op;
   logic       alu_srcb;

   modport master (
      output start, opcode, zero, stack_empty, stack_full,
      input  busy, trap, instr_done, pc_write, pc_src, iord, mem_read, mem_write,
             ir_write, mdr_load, push, pop, push_src, a_load, b_load, alu_op, alu_srcb
   );

   modport slave (
      input  start, opcode, zero, stack_empty, stack_full,
      output busy, trap, instr_done, pc_write, pc_src, iord, mem_read, mem_write,
             ir_write, mdr_load, push, pop, push_src, a_load, b_load, alu_op, alu_srcb
   );
endinterface

// File: rtl/stack_ctrl_fsm.sv
// Multicycle control FSM for the 8-bit stack processor: fetch, decode, stack
// pop/push, memory access and branches, with a sticky trap on stack errors.
module stack_ctrl_fsm (
   input  logic            clk,
   input  logic            rst_n,
   stack_ctrl_fsm_if.slave bus
);
   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_NOT  = 3'd3;
   localparam logic [2:0] OP_PUSH = 3'd4;
   localparam logic [2:0] OP_POP  = 3'd5;
   localparam logic [2:0] OP_JMP  = 3'd6;
   localparam logic [2:0] OP_JZ   = 3'd7;

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, POP_A, POP_B, ALU_WB, PUSH_RD, PUSH_WB,
      POP_RD, POP_WR, JMP, JZ_TOS, JZ_EVAL, TRAP
   } state_t;

   state_t     state, state_nxt;
   logic [2:0] op_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // IR is stable after FETCH; keep the opcode for the ALU states.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               op_q <= OP_ADD;
      else if (state == DECODE) op_q <= bus.opcode;
   end

   always_comb begin
      state_nxt      = state;
      bus.busy       = (state != IDLE) && (state != TRAP);
      bus.trap       = (state == TRAP);
      bus.instr_done = 1'b0;
      bus.pc_write   = 1'b0;
      bus.pc_src     = 1'b0;
      bus.iord       = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.mdr_load   = 1'b0;
      bus.push       = 1'b0;
      bus.pop        = 1'b0;
      bus.push_src   = 1'b0;
      bus.a_load     = 1'b0;
      bus.b_load     = 1'b0;
      bus.alu_op     = 2'b00;
      bus.alu_srcb   = 1'b0;

      case (state)
         IDLE: if (bus.start) state_nxt = FETCH;
         FETCH: begin
            bus.mem_read = 1'b1;
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_nxt    = DECODE;
         end
         DECODE: begin
            case (bus.opcode)
               OP_PUSH: state_nxt = bus.stack_full  ? TRAP : PUSH_RD;
               OP_POP:  state_nxt = bus.stack_empty ? TRAP : POP_RD;
               OP_JMP:  state_nxt = JMP;
               OP_JZ:   state_nxt = bus.stack_empty ? TRAP : JZ_TOS;
               default: state_nxt = bus.stack_empty ? TRAP : POP_A;
            endcase
         end
         POP_A: begin
            bus.pop    = 1'b1;
            bus.a_load = 1'b1;
            // Datapath flags empty here when this pop takes the last entry.
            if (op_q == OP_NOT)       state_nxt = ALU_WB;
            else if (bus.stack_empty) state_nxt = TRAP;
            else                      state_nxt = POP_B;
         end
         POP_B: begin
            bus.pop    = 1'b1;
            bus.b_load = 1'b1;
            state_nxt  = ALU_WB;
         end
         ALU_WB: begin
            bus.push       = 1'b1;
            bus.instr_done = 1'b1;
            case (op_q)
               OP_SUB:  bus.alu_op = 2'b01;
               OP_NOT:  bus.alu_op = 2'b10;
               OP_AND:  bus.alu_op = 2'b11;
               default: bus.alu_op = 2'b00;
            endcase
            state_nxt = FETCH;
         end
         PUSH_RD: begin
            bus.mem_read = 1'b1;
            bus.iord     = 1'b1;
            bus.mdr_load = 1'b1;
            state_nxt    = PUSH_WB;
         end
         PUSH_WB: begin
            bus.push       = 1'b1;
            bus.push_src   = 1'b1;
            bus.instr_done = 1'b1;
            state_nxt      = FETCH;
         end
         POP_RD: begin
            bus.pop    = 1'b1;
            bus.a_load = 1'b1;
            state_nxt  = POP_WR;
         end
         POP_WR: begin
            bus.mem_write  = 1'b1;
            bus.iord       = 1'b1;
            bus.instr_done = 1'b1;
            state_nxt      = FETCH;
         end
         JMP: begin
            bus.pc_write   = 1'b1;
            bus.pc_src     = 1'b1;
            bus.instr_done = 1'b1;
            state_nxt      = FETCH;
         end
         JZ_TOS: begin
            bus.a_load = 1'b1;
            state_nxt  = JZ_EVAL;
         end
         JZ_EVAL: begin
            bus.alu_srcb   = 1'b1;
            bus.pc_write   = bus.zero;
            bus.pc_src     = 1'b1;
            bus.instr_done = 1'b1;
            state_nxt      = FETCH;
         end
         TRAP:    state_nxt = TRAP;
         default: state_nxt = IDLE;
      endcase
   end
endmodule
